// File: rtl/stack_ctrl.sv
// Data-stack controller: cached TOS/NOS registers backed by a synchronous-read RAM,
// serving PUSH / POP / POP2PUSH requests over a req/ack handshake.
module stack_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int DW = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] wdata,
    output logic             ack,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_P2P  = 2'b11;
    localparam logic [DW-1:0] FULL_DEPTH = DW'(DEPTH + 2);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             fault;
    logic             refill;
    logic             spill;
    logic [AW-1:0]    spill_addr;
    logic [AW-1:0]    fill_addr;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (depth == '0);
    assign full  = (depth == FULL_DEPTH);
    assign ack   = (state == DONE);

    // sp = depth-2 is the next spill slot; the element just below NOS lives at sp-1.
    assign spill_addr = AW'(depth - DW'(2));
    assign fill_addr  = AW'(depth - DW'(3));

    always_comb begin
        state_next = state;
        accept     = (state == IDLE) && req;
        fault      = 1'b0;
        refill     = 1'b0;
        spill      = 1'b0;
        case (cmd)
            CMD_PUSH: fault = full;
            CMD_POP:  fault = empty;
            CMD_P2P:  fault = (depth < DW'(2));
            default:  fault = 1'b0;
        endcase
        if (accept && !fault) begin
            refill = ((cmd == CMD_POP) || (cmd == CMD_P2P)) && (depth >= DW'(3));
            spill  = (cmd == CMD_PUSH) && (depth >= DW'(2));
        end
        case (state)
            IDLE:    if (req) state_next = refill ? FILL : DONE;
            FILL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos   <= '0;
            nos   <= '0;
            rdata <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            err <= fault;
            if (!fault) begin
                case (cmd)
                    CMD_PUSH: begin
                        nos   <= tos;
                        tos   <= wdata;
                        depth <= depth + DW'(1);
                    end
                    CMD_POP: begin
                        rdata <= tos;
                        tos   <= nos;
                        depth <= depth - DW'(1);
                        if (!refill) nos <= '0;
                    end
                    CMD_P2P: begin
                        rdata <= tos;
                        tos   <= wdata;
                        depth <= depth - DW'(1);
                        if (!refill) nos <= '0;
                    end
                    default: ;
                endcase
            end
        end else if (state == FILL) begin
            nos <= ram_q;
        end
    end

    // Backing store is never cleared; only words below the live depth are ever read.
    always_ff @(posedge clk) begin
        if (rst_n && spill)  mem[spill_addr] <= nos;
        if (rst_n && refill) ram_q <= mem[fill_addr];
    end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Data-stack controller for the 16-bit stack CPU. It owns the cached TOS/NOS registers and a synchronous-read backing RAM. It executes PUSH, POP and POP2PUSH requests from the CPU sequencer over a req/ack handshake. It spills to and refills from the RAM transparently and flags overflow and underflow.

Parameters:
WIDTH, 16, data word width
DEPTH, 16, backing RAM entries (power of 2, ≥2); total capacity DEPTH+2 (RAM + TOS + NOS)
DW (localparam), $clog2(DEPTH+3), width of depth count

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
req  in  1  operation request; sampled only in IDLE
cmd  in  2  00 NOP, 01 PUSH, 10 POP, 11 POP2PUSH
wdata  in  WIDTH  push value / POP2PUSH result (e.g. TOS+NOS computed by CPU)
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack; 1 = overflow/underflow, op suppressed
rdata  out  WIDTH  value removed by last POP/POP2PUSH (old TOS); held until next pop
tos  out  WIDTH  top of stack register (0 when depth<1)
nos  out  WIDTH  next on stack register (0 when depth<2)
depth  out  DW  element count, 0..DEPTH+2
empty  out  1  depth==0 (combinational from depth)
full  out  1  depth==DEPTH+2 (combinational)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock is clk, reset is rst_n.
- Reset (rst_n=0 at an edge): state=IDLE, tos=nos=rdata=0, depth=0, ack=0, err=0. RAM contents are not cleared. Reset wins over any in-flight op, including in FILL.
- Internal sp = depth-2 when depth≥2: RAM write index for spill; a refill reads sp-1.
- FSM: IDLE, FILL, DONE. ack=1 only in DONE; DONE always returns to IDLE next cycle. req is ignored outside IDLE, so the requester may hold req through DONE without a double accept. Max throughput is one op per 2 cycles.
- NOP (req in IDLE): no state change → DONE, err=0.
- PUSH:
  - If full: err=1, no change → DONE.
  - Else: nos←tos, tos←wdata, depth+1.
  - If depth≥2 before the op: ram[sp]←nos (old NOS), sp+1.
  - → DONE. Latency: ack in cycle after acceptance.
- POP:
  - If depth==0: err=1, no change → DONE.
  - Else: rdata←tos, tos←nos, depth−1.
  - If depth≥3 before the op: issue RAM read of ram[sp-1] → FILL; in FILL nos←ram_q → DONE. ack 2 cycles after acceptance.
  - Else nos←0 → DONE (ack 1 cycle after).
- POP2PUSH (pop two, push wdata):
  - If depth<2: err=1, no change → DONE.
  - Else: rdata←tos, tos←wdata, depth−1.
  - Refill NOS exactly as POP: via FILL if depth≥3 before the op, else nos←0.
- Spill/fill ordering: the refill reads the RAM address written by the most recent spill. No read-during-write conflict is possible, since only one op is in flight.
- err is cleared on every ack without fault. rdata is unchanged on err or on PUSH/NOP.
- Arithmetic: depth is never wrapped; the full/empty checks guarantee 0≤depth≤DEPTH+2.
- cmd and wdata are sampled only on the accept edge. Changes afterwards have no effect.

Test Plan:
- Reset then push 0x0011, 0x0022, 0x0033 → after each ack depth 1/2/3; final tos=0x0033, nos=0x0022, ram[0]=0x0011, err=0.
- DEPTH=4: push 1..6 → full=1, depth=6. Push 7 → ack with err=1; tos=6, nos=5, depth=6 unchanged.
- From that full stack, POP → ack exactly 2 cycles after acceptance (FILL path). rdata=6, tos=5, nos=4, depth=5.
- Stack [..,0x0005,0x0003] with depth 3: POP2PUSH wdata=0x0008 → rdata=0x0003, tos=0x0008, nos=refilled lower value, depth=2. At depth 1: POP2PUSH → err=1, no change.
- From reset: POP → err=1, depth=0. Push 0x00AA, POP → rdata=0x00AA, tos=0, empty=1, ack 1 cycle after acceptance.
- Assert rst_n=0 while in FILL → next cycle IDLE, depth=0, tos=nos=0, ack=0. A subsequent PUSH behaves as from reset.
